// File: rtl/dt1_muldiv_seq_if.sv
// Execute-stage handshake between the IE datapath and the RV32M multiply/divide sequencer.
interface dt1_muldiv_seq_if #(
   parameter int unsigned XLEN = 32
);
   logic            StartE;
   logic            FlushE;
   logic [2:0]      Funct3E;
   logic [XLEN-1:0] SrcAE;
   logic [XLEN-1:0] SrcBE;
   logic            StallMDE;
   logic            DoneE;
   logic [XLEN-1:0] MDResultE;

   modport master (
      output StartE, FlushE, Funct3E, SrcAE, SrcBE,
      input  StallMDE, DoneE, MDResultE
   );

   modport slave (
      input  StartE, FlushE, Funct3E, SrcAE, SrcBE,
      output StallMDE, DoneE, MDResultE
   );
endinterface

// File: rtl/dt1_muldiv_seq.sv
// RV32M multi-cycle sequencer: 32-step shift-add multiply / restoring divide on magnitudes,
// with sign fix-up in a final cycle and a one-cycle DoneE result pulse.
module dt1_muldiv_seq #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned ITER = XLEN
) (
   input  logic             clk,
   input  logic             rst,
   dt1_muldiv_seq_if.slave  md
);
   localparam int unsigned CW = $clog2(ITER);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t            state, stateNext;
   logic [2:0]        op;
   logic [CW-1:0]     cnt;
   logic              negQ, negR;
   logic [XLEN-1:0]   hi, lo, dvs, result;

   // Operand decode for the instruction presented in IDLE
   logic              isDiv, aSigned, bSigned, aNeg, bNeg, divZero, divOvf, special, accept;
   logic [XLEN-1:0]   aMag, bMag, specRes;

   assign isDiv   = md.Funct3E[2];
   assign aSigned = isDiv ? ~md.Funct3E[0] : (md.Funct3E == 3'b001 || md.Funct3E == 3'b010);
   assign bSigned = isDiv ? ~md.Funct3E[0] : (md.Funct3E == 3'b001);
   assign aNeg    = aSigned & md.SrcAE[XLEN-1];
   assign bNeg    = bSigned & md.SrcBE[XLEN-1];
   assign aMag    = aNeg ? -md.SrcAE : md.SrcAE;
   assign bMag    = bNeg ? -md.SrcBE : md.SrcBE;
   assign divZero = isDiv & (md.SrcBE == '0);
   assign divOvf  = isDiv & ~md.Funct3E[0] & (md.SrcAE == {1'b1, {(XLEN-1){1'b0}}}) & (md.SrcBE == '1);
   assign special = divZero | divOvf;
   // Overflow case: dividend is 0x80000000, which is also the DIV answer
   assign specRes = divZero ? (md.Funct3E[1] ? md.SrcAE : '1)
                            : (md.Funct3E[1] ? '0 : md.SrcAE);
   assign accept  = (state == IDLE) & md.StartE & ~md.FlushE;

   // One iteration of each algorithm; {hi,lo} holds acc/multiplier or rem/quotient
   logic [XLEN:0]     sum, shifted;
   logic              geq;
   logic [XLEN-1:0]   stepHi, stepLo;

   assign sum     = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
   assign shifted = {hi, lo[XLEN-1]};
   assign geq     = shifted >= {1'b0, dvs};
   assign stepHi  = op[2] ? (geq ? shifted[XLEN-1:0] - dvs : shifted[XLEN-1:0]) : sum[XLEN:1];
   assign stepLo  = op[2] ? {lo[XLEN-2:0], geq} : {sum[0], lo[XLEN-1:1]};

   logic [2*XLEN-1:0] prodFix;
   logic [XLEN-1:0]   quoFix, remFix, fixRes;

   assign prodFix = negQ ? -{hi, lo} : {hi, lo};
   assign quoFix  = negQ ? -lo : lo;
   assign remFix  = negR ? -hi : hi;

   always_comb begin
      fixRes = remFix;
      case (op)
         3'b000:                 fixRes = prodFix[XLEN-1:0];
         3'b001, 3'b010, 3'b011: fixRes = prodFix[2*XLEN-1:XLEN];
         3'b100, 3'b101:         fixRes = quoFix;
         default:                fixRes = remFix;
      endcase
   end

   always_comb begin
      stateNext   = state;
      md.StallMDE = 1'b0;
      md.DoneE    = 1'b0;
      case (state)
         IDLE: begin
            md.StallMDE = rst & md.StartE & ~md.FlushE;
            if (accept) stateNext = special ? DONE : CALC;
         end
         CALC: begin
            md.StallMDE = 1'b1;
            if (md.FlushE)                      stateNext = IDLE;
            else if (cnt == CW'(ITER - 1))      stateNext = FIX;
         end
         FIX: begin
            md.StallMDE = 1'b1;
            stateNext   = md.FlushE ? IDLE : DONE;
         end
         DONE: begin
            md.DoneE  = 1'b1;
            stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   assign md.MDResultE = result;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         op     <= '0;
         cnt    <= '0;
         negQ   <= 1'b0;
         negR   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
         dvs    <= '0;
         result <= '0;
      end else begin
         state <= stateNext;
         case (state)
            IDLE: if (accept) begin
               op   <= md.Funct3E;
               negQ <= aNeg ^ bNeg;
               negR <= aNeg;
               cnt  <= '0;
               hi   <= '0;
               lo   <= aMag;
               dvs  <= bMag;
               if (special) result <= specRes;
            end
            CALC: begin
               hi  <= stepHi;
               lo  <= stepLo;
               cnt <= cnt + CW'(1);
            end
            FIX: if (!md.FlushE) result <= fixRes;
            default: ;
         endcase
      end
   end
endmodule
